// File: rtl/ifft_ctrl_pkg.sv
// rtl/ifft_ctrl_pkg.sv - shared FFT sample/packet types, controller state enum, bit-reverse helper.
// IFFT_CTRL_BITREV_EN selects bit-reversed load order in load_slot().
`ifndef NUM_FFT_POINT
`define NUM_FFT_POINT 8
`endif

package ifft_ctrl_pkg;

  localparam int NPTS = `NUM_FFT_POINT;

  // Q16.16 real and imaginary parts
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } COMPLEX_NUMBER;

  typedef COMPLEX_NUMBER FFT_INPUT_PACKET;
  typedef COMPLEX_NUMBER FFT_OUTPUT_PACKET;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } ifft_state_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic logic [2:0] load_slot(input logic [2:0] k);
`ifdef IFFT_CTRL_BITREV_EN
    return bitrev3(k);
`else
    return k;
`endif
  endfunction

endpackage

// File: rtl/ifft_ctrl.sv
// rtl/ifft_ctrl.sv - 8-point IFFT frame controller: load, wait on datapath latency, drain in natural order.
// Load ordering follows load_slot(), which is bit-reversed when IFFT_CTRL_BITREV_EN is defined.
module ifft_ctrl
  import ifft_ctrl_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  COMPLEX_NUMBER                     in_data,
  output FFT_INPUT_PACKET  [NPTS-1:0]       fft_in,
  input  FFT_OUTPUT_PACKET [NPTS-1:0]       fft_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output COMPLEX_NUMBER                     out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic             [CNT_W-1:0]      frame_count
);

  localparam int LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  ifft_state_e                   state_q, state_d;
  logic [2:0]                    wr_idx_q, wr_idx_d;
  logic [2:0]                    rd_idx_q, rd_idx_d;
  logic [LAT_W-1:0]              lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]              frame_count_q, frame_count_d;
  FFT_INPUT_PACKET  [NPTS-1:0]   ibuf_q, ibuf_d;
  FFT_OUTPUT_PACKET [NPTS-1:0]   obuf_q, obuf_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          busy_q, busy_d;
  COMPLEX_NUMBER                 out_data_q, out_data_d;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    lat_cnt_d     = lat_cnt_q;
    frame_count_d = frame_count_q;
    ibuf_d        = ibuf_q;
    obuf_d        = obuf_q;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          ibuf_d[load_slot(wr_idx_q)] = in_data;
          wr_idx_d = wr_idx_q + 3'd1;
          if (wr_idx_q == 3'd7) begin
            state_d   = WAIT;
            lat_cnt_d = LAT_W'(LATENCY);
          end
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(1)) begin
          obuf_d  = fft_out;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          rd_idx_d = rd_idx_q + 3'd1;
          if (rd_idx_q == 3'd7) begin
            state_d       = LOAD;
            frame_count_d = frame_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
    // Outputs are registered from next-state values so they line up with the state they describe.
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d != LOAD);
    out_valid_d = (state_d == DRAIN);
    out_last_d  = out_valid_d && (rd_idx_d == 3'd7);
    out_data_d  = out_valid_d ? obuf_d[rd_idx_d] : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= LOAD;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      lat_cnt_q     <= '0;
      frame_count_q <= '0;
      ibuf_q        <= '0;
      obuf_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      lat_cnt_q     <= lat_cnt_d;
      frame_count_q <= frame_count_d;
      ibuf_q        <= ibuf_d;
      obuf_q        <= obuf_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      out_data_q    <= out_data_d;
    end
  end

  assign fft_in      = ibuf_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign out_data    = out_data_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ifft_ctrl.sv
// tb/tb_ifft_ctrl.sv - randomized bench for ifft_ctrl with a frame-level reference model and an IFFT datapath stand-in.
module tb_ifft_ctrl;
  import ifft_ctrl_pkg::*;

  localparam int LAT = 3;
  localparam int CW  = 16;

  typedef COMPLEX_NUMBER [7:0] frame_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  COMPLEX_NUMBER in_data = '0;
  frame_t        fft_in;
  frame_t        fft_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  COMPLEX_NUMBER out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] frame_count;

  ifft_ctrl #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fft_in(fft_in), .fft_out(fft_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  function automatic logic signed [31:0] rnd(input real v);
    return $rtoi($floor(v + 0.5));
  endfunction

  // Reference 8-point inverse DFT with 1/N scaling, natural order in and out.
  function automatic frame_t ifft8(input frame_t x);
    frame_t y;
    real sr, si, a;
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        a  = 2.0 * 3.14159265358979 * n * k / 8.0;
        sr = sr + x[n].re * $cos(a) - x[n].im * $sin(a);
        si = si + x[n].re * $sin(a) + x[n].im * $cos(a);
      end
      y[k].re = rnd(sr / 8.0);
      y[k].im = rnd(si / 8.0);
    end
    return y;
  endfunction

  function automatic int slot(input int k);
`ifdef IFFT_CTRL_BITREV_EN
    return rev(k);
`else
    return k;
`endif
  endfunction

  // Datapath stand-in: undo the load permutation, then transform.
  always_comb begin
    frame_t nat_v;
    nat_v = '0;
    for (int k = 0; k < 8; k++) nat_v[k] = fft_in[slot(k)];
    fft_out = ifft8(nat_v);
  end

  // Frame-level model state
  frame_t        m_ibuf = '0;
  frame_t        m_nat  = '0;
  COMPLEX_NUMBER exp_q[$];
  int            m_n_in = 0;
  int            m_wait = 0;
  int            m_fc   = 0;
  int            m_oidx = 0;
  COMPLEX_NUMBER log_d[8];
  logic          log_l[8];

  initial begin
    frame_t        res;
    logic          e_ir, e_ov;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        m_ibuf = '0; m_nat = '0; m_n_in = 0; m_wait = 0; m_fc = 0; m_oidx = 0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_frame_count", frame_count, '0);
        chk("rst_fft_in", fft_in, '0);
      end else begin
        e_ir = (exp_q.size() == 0);
        e_ov = (exp_q.size() != 0) && (m_wait == 0);
        chk("in_ready", in_ready, e_ir);
        chk("busy", busy, !e_ir);
        chk("out_valid", out_valid, e_ov);
        chk("frame_count", frame_count, CW'(m_fc));
        chk("fft_in", fft_in, m_ibuf);
        if (e_ov) begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_last", out_last, (m_oidx == 7));
        end else begin
          chk("out_last_idle", out_last, 1'b0);
        end
        if (in_valid && e_ir) begin
          m_nat[m_n_in] = in_data;
          m_ibuf[slot(m_n_in)] = in_data;
          m_n_in++;
          if (m_n_in == 8) begin
            res = ifft8(m_nat);
            for (int k = 0; k < 8; k++) exp_q.push_back(res[k]);
            m_wait = LAT;
            m_n_in = 0;
          end
        end else if (m_wait > 0) begin
          m_wait--;
        end else if (e_ov && out_ready) begin
          log_d[m_oidx] = out_data;
          log_l[m_oidx] = out_last;
          void'(exp_q.pop_front());
          m_oidx++;
          if (m_oidx == 8) begin
            m_oidx = 0;
            m_fc++;
          end
        end
      end
    end
  end

  int or_mode = 0;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  function automatic COMPLEX_NUMBER rand_c();
    COMPLEX_NUMBER c;
    c.re = int'($urandom_range(0, 2097152)) - 1048576;
    c.im = int'($urandom_range(0, 2097152)) - 1048576;
    return c;
  endfunction

  task automatic send(input frame_t s, input int n, input int vpct);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 400) begin
      @(posedge clock);
      #1;
      in_valid = (int'($urandom_range(99)) < vpct);
      in_data  = s[i];
      @(negedge clock);
      if (in_valid && in_ready) i++;
      guard++;
    end
    if (i < n) begin
      errors++;
      $display("FAIL send_timeout: got %0d samples expected %0d", i, n);
    end
  endtask

  // Keeps junk in_valid high while the frame is in flight; the model proves it is ignored.
  task automatic drain();
    int start = m_fc;
    int guard = 0;
    forever begin
      @(posedge clock);
      #1;
      if (m_fc != start) break;
      if (guard >= 600) begin
        errors++;
        $display("FAIL drain_timeout: got frame_count %0d expected %0d", m_fc, start + 1);
        break;
      end
      in_valid = 1'b1;
      in_data  = rand_c();
      guard++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    frame_t f;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // DC frame
    for (int k = 0; k < 8; k++) begin f[k].re = 32'h0001_0000; f[k].im = 0; end
    send(f, 8, 100);
    drain();
    chk("dc_out0", log_d[0], {32'h0001_0000, 32'h0});
    for (int k = 1; k < 8; k++) chk($sformatf("dc_out%0d", k), log_d[k], 64'd0);
    chk("dc_last7", log_l[7], 1'b1);
    chk("dc_last6", log_l[6], 1'b0);
    chk("dc_fc", frame_count, CW'(1));

    // Impulse
    f = '0;
    f[0].re = 32'h0008_0000;
    send(f, 8, 100);
    drain();
    for (int k = 0; k < 8; k++) chk($sformatf("imp_out%0d", k), log_d[k], {32'h0001_0000, 32'h0});

    // Backpressure toggling
    or_mode = 1;
    for (int k = 0; k < 8; k++) f[k] = rand_c();
    send(f, 8, 100);
    drain();
    chk("bp_fc", frame_count, CW'(3));
    or_mode = 0;

    // Abort after 5 accepted samples
    for (int k = 0; k < 8; k++) f[k] = rand_c();
    send(f, 5, 100);
    @(posedge clock);
    #1 reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin f[k].re = 32'h0001_0000; f[k].im = 0; end
    send(f, 8, 100);
    drain();
    chk("abort_fc", frame_count, CW'(1));
    chk("abort_out0", log_d[0], {32'h0001_0000, 32'h0});

`ifdef IFFT_CTRL_BITREV_EN
    for (int k = 0; k < 8; k++) begin f[k].re = k << 16; f[k].im = 0; end
    send(f, 8, 100);
    @(negedge clock);
    for (int j = 0; j < 8; j++) chk($sformatf("bitrev_fft_in%0d", j), fft_in[j].re, 32'(rev(j) << 16));
    drain();
`endif

    // Random frames with random valid density and backpressure
    or_mode = 2;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) f[k] = rand_c();
      send(f, 8, 60);
      drain();
    end
    or_mode = 0;
    repeat (4) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifft_ctrl.md
IFFT_CTRL -- requirements
Module: ifft_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 3, giving the datapath cycles from frame presentation to valid result (one registered butterfly stage per cycle).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of frame_count.
REQ-003 clock  in  1  single clock; all state is updated on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream sample valid.
REQ-006 in_ready  out  1  controller accepts a sample.
REQ-007 in_data  in  COMPLEX_NUMBER (64)  one Q16.16 complex sample.
REQ-008 fft_in  out  FFT_INPUT_PACKET[`NUM_FFT_POINT]  held frame driven to the IFFT datapath.
REQ-009 fft_out  in  FFT_OUTPUT_PACKET[`NUM_FFT_POINT]  datapath result.
REQ-010 out_valid  out  1  output sample valid.
REQ-011 out_ready  in  1  downstream accepts.
REQ-012 out_data  out  COMPLEX_NUMBER (64)  one result sample.
REQ-013 out_last  out  1  marks index 7 of a frame.
REQ-014 busy  out  1  high in any state other than LOAD.
REQ-015 frame_count  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Function
REQ-016 The FSM SHALL have three states, LOAD, WAIT and DRAIN, with exactly one frame in flight.
REQ-017 In LOAD: in_ready=1; each in_valid&in_ready handshake SHALL write in_data to ibuf[wr_idx], then increment wr_idx (3 bits).
REQ-018 On the handshake with wr_idx==7: SHALL go to WAIT, load lat_cnt=LATENCY, and reset wr_idx to 0.
REQ-019 fft_in SHALL equal ibuf at all times, and ibuf SHALL be stable throughout WAIT.
REQ-020 In WAIT: in_ready=0; lat_cnt decrements every cycle; in the cycle lat_cnt==1, fft_out SHALL be captured into obuf and the FSM SHALL go to DRAIN.
REQ-021 In DRAIN: out_valid=1, out_data=obuf[rd_idx], out_last=(rd_idx==7); rd_idx SHALL advance only on an out_valid&out_ready handshake.
REQ-022 On the handshake with out_last: SHALL go to LOAD, clear rd_idx, and increment frame_count.
REQ-023 out_valid and out_data SHALL stay stable while out_ready=0 (no drop, no duplicate).
REQ-024 in_valid outside LOAD SHALL be ignored, with no buffer write.
REQ-025 Input-to-first-output latency SHALL be 8 accepted samples, then LATENCY cycles, then 1 cycle.
REQ-026 No arithmetic SHALL occur in this block; samples pass bit-exact.

Reset
REQ-027 Asserting reset SHALL force LOAD and zero wr_idx, rd_idx, lat_cnt, frame_count, ibuf and obuf.
REQ-028 After reset, in_ready=1, out_valid=0, out_last=0, busy=0 and out_data=0.
REQ-029 Reset mid-frame (any state) SHALL discard the partial frame, with no output produced for it.

Configuration
REQ-030 With IFFT_CTRL_BITREV_EN defined, LOAD SHALL write sample k to ibuf[bitrev3(k)] (e.g. k=1 to 4, k=3 to 6).
REQ-031 Without IFFT_CTRL_BITREV_EN, LOAD SHALL write sample k to ibuf[k]; output order is natural in both cases.

Structure
REQ-032 COMPLEX_NUMBER, FFT_INPUT_PACKET, FFT_OUTPUT_PACKET, `NUM_FFT_POINT and the FSM state enum SHALL live in the shared FFT package/header.
REQ-033 The controller SHALL not instantiate the datapath; the top level connects fft_in/fft_out to ifft_top.
REQ-034 No sub-module is required; the bit-reverse SHALL be a package function.

Verification
REQ-035 DC frame: 8 samples of real=0x00010000, imag=0 with out_ready=1 -> out[0].real=0x00010000, out[1..7]=0; out_last on the 8th output; frame_count=1.
REQ-036 Impulse: x[0]=0x00080000, rest 0 -> all 8 outputs real=0x00010000, imag=0.
REQ-037 Backpressure: out_ready toggles 1/0 every cycle -> each out_data held while stalled; exactly 8 outputs; in_ready=0 until the last handshake.
REQ-038 Reset asserted after 5 accepted samples -> next 8 samples form a fresh frame; no out_valid for the aborted frame.
REQ-039 in_valid held high during WAIT/DRAIN -> in_ready=0, ibuf unchanged, next frame starts in LOAD only.
REQ-040 With IFFT_CTRL_BITREV_EN: inputs 0..7 as real=k<<16 -> fft_in[j].real=bitrev3(j)<<16, checked in the first WAIT cycle.
